// File: rtl/uart_fifo_ctrl_if.sv
// uart_fifo_ctrl_if: core byte streams, status and uart_controller handshake for uart_fifo_ctrl
interface uart_fifo_ctrl_if #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic           rx_overflow;
  logic           overflow_clear;
  logic [7:0]     uart_send_data;
  logic           uart_send;
  logic           uart_send_busy;
  logic [7:0]     uart_rev_data;
  logic           uart_rev_data_valid;
  logic           uart_rev_data_invalid;
  modport master (
    output tx_data, tx_valid, rx_ready, overflow_clear, uart_send_busy, uart_rev_data, uart_rev_data_valid,
    input  tx_ready, rx_data, rx_valid, tx_count, rx_count, rx_overflow, uart_send_data, uart_send, uart_rev_data_invalid
  );
  modport slave (
    input  tx_data, tx_valid, rx_ready, overflow_clear, uart_send_busy, uart_rev_data, uart_rev_data_valid,
    output tx_ready, rx_data, rx_valid, tx_count, rx_count, rx_overflow, uart_send_data, uart_send, uart_rev_data_invalid
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: TX/RX byte FIFOs sequencing a uart_controller send/receive handshake
module uart_fifo_ctrl #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  uart_fifo_ctrl_if.slave bus
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);
  typedef enum logic [1:0] {TX_IDLE, TX_ISSUE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_LOW} rx_state_e;
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TCW-1:0] tx_count_q, tx_count_d;
  logic [RCW-1:0] rx_count_q, rx_count_d;
  logic           rx_overflow_q, rx_overflow_d;
  logic           tx_push, tx_pop, rx_push, rx_pop, rx_cap, rx_drop, rx_full;
  tx_state_e      tx_state_q;
  rx_state_e      rx_state_q;
  logic           uart_send_q, rev_ack_q;
  logic [7:0]     uart_send_data_q;
  always_comb begin
    tx_push       = bus.tx_valid && tx_count_q != TX_FULL;
    tx_pop        = tx_state_q == TX_IDLE && tx_count_q != '0 && !bus.uart_send_busy;
    rx_pop        = bus.rx_ready && rx_count_q != '0;
    rx_cap        = rx_state_q == RX_IDLE && bus.uart_rev_data_valid;
    // a pop in the capture cycle frees the slot the incoming byte needs
    rx_full       = rx_count_q == RX_FULL && !rx_pop;
    rx_push       = rx_cap && !rx_full;
    rx_drop       = rx_cap && rx_full;
    tx_wr_d       = tx_wr_q + TAW'(tx_push);
    tx_rd_d       = tx_rd_q + TAW'(tx_pop);
    tx_count_d    = tx_count_q + TCW'(tx_push) - TCW'(tx_pop);
    rx_wr_d       = rx_wr_q + RAW'(rx_push);
    rx_rd_d       = rx_rd_q + RAW'(rx_pop);
    rx_count_d    = rx_count_q + RCW'(rx_push) - RCW'(rx_pop);
    rx_overflow_d = rx_drop ? 1'b1 : bus.overflow_clear ? 1'b0 : rx_overflow_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      tx_count_q    <= '0;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      rx_count_q    <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      tx_count_q    <= tx_count_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      rx_count_q    <= rx_count_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus.tx_data;
    if (rx_push) rx_mem[rx_wr_q] <= bus.uart_rev_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q       <= TX_IDLE;
      uart_send_q      <= 1'b0;
      uart_send_data_q <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (tx_pop) begin
          uart_send_data_q <= tx_mem[tx_rd_q];
          tx_state_q       <= TX_ISSUE;
        end
        TX_ISSUE: begin
          uart_send_q <= 1'b1;
          tx_state_q  <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          uart_send_q <= 1'b0;
          if (bus.uart_send_busy) tx_state_q <= TX_WAIT_DONE;
        end
        TX_WAIT_DONE: if (!bus.uart_send_busy) tx_state_q <= TX_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rev_ack_q  <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: if (bus.uart_rev_data_valid) begin
          rev_ack_q  <= 1'b1;
          rx_state_q <= RX_ACK;
        end
        RX_ACK: begin
          rev_ack_q  <= 1'b0;
          rx_state_q <= RX_WAIT_LOW;
        end
        RX_WAIT_LOW: if (!bus.uart_rev_data_valid) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
  assign bus.tx_ready              = tx_count_q != TX_FULL;
  assign bus.rx_valid              = rx_count_q != '0;
  assign bus.rx_data               = rx_mem[rx_rd_q];
  assign bus.tx_count              = tx_count_q;
  assign bus.rx_count              = rx_count_q;
  assign bus.rx_overflow           = rx_overflow_q;
  assign bus.uart_send             = uart_send_q;
  assign bus.uart_send_data        = uart_send_data_q;
  assign bus.uart_rev_data_invalid = rev_ack_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed tests of uart_fifo_ctrl against a small uart_controller model
module tb_uart_fifo_ctrl;
  localparam int FRAME = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  logic busy_force = 1'b0;
  logic [7:0] sent_q [$];
  uart_fifo_ctrl_if #(.TX_DEPTH(16), .RX_DEPTH(16)) u_if ();
  uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(u_if.slave));
  always #5 clk = ~clk;
  assign u_if.uart_send_busy = (busy_cnt != 0) || busy_force;
  always @(posedge clk) begin
    if (u_if.uart_send) begin
      total++;
      if (u_if.uart_send_busy) begin
        bad++;
        $display("FAIL send_while_busy: uart_send=1 with busy=1, required no send");
      end
      sent_q.push_back(u_if.uart_send_data);
      busy_cnt <= FRAME;
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_sent(input int n, input int budget);
    int c = 0;
    while (sent_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (sent_q.size() < n) begin
      bad++;
      $display("FAIL wait_sent: got %0d frames, required %0d", sent_q.size(), n);
    end
  endtask
  task automatic send_rx(input logic [7:0] b, input logic clr, output int pulses);
    u_if.uart_rev_data = b;
    u_if.uart_rev_data_valid = 1'b1;
    u_if.overflow_clear = clr;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      u_if.overflow_clear = 1'b0;
      if (u_if.uart_rev_data_invalid) begin
        pulses++;
        u_if.uart_rev_data_valid = 1'b0;
      end
    end
    u_if.uart_rev_data_valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total += 8;
    if (u_if.tx_count !== 5'd0) begin bad++; $display("FAIL rst_tx_count: got %0d, required 0", u_if.tx_count); end
    if (u_if.rx_count !== 5'd0) begin bad++; $display("FAIL rst_rx_count: got %0d, required 0", u_if.rx_count); end
    if (u_if.rx_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b, required 0", u_if.rx_overflow); end
    if (u_if.uart_send !== 1'b0) begin bad++; $display("FAIL rst_send: got %b, required 0", u_if.uart_send); end
    if (u_if.uart_send_data !== 8'h00) begin bad++; $display("FAIL rst_send_data: got %h, required 00", u_if.uart_send_data); end
    if (u_if.uart_rev_data_invalid !== 1'b0) begin bad++; $display("FAIL rst_invalid: got %b, required 0", u_if.uart_rev_data_invalid); end
    if (u_if.tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready: got %b, required 1", u_if.tx_ready); end
    if (u_if.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b, required 0", u_if.rx_valid); end
  endtask
  task automatic test_single_tx();
    sent_q.delete();
    u_if.tx_data = 8'h55;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    total++;
    if (u_if.tx_count !== 5'd1) begin bad++; $display("FAIL single_count1: got %0d, required 1", u_if.tx_count); end
    @(negedge clk);
    total += 3;
    if (u_if.tx_count !== 5'd0) begin bad++; $display("FAIL single_count0: got %0d, required 0", u_if.tx_count); end
    if (u_if.uart_send !== 1'b0) begin bad++; $display("FAIL single_early_send: got %b, required 0", u_if.uart_send); end
    if (u_if.uart_send_data !== 8'h55) begin bad++; $display("FAIL single_data: got %h, required 55", u_if.uart_send_data); end
    @(negedge clk);
    total++;
    if (u_if.uart_send !== 1'b1) begin bad++; $display("FAIL single_send_hi: got %b, required 1", u_if.uart_send); end
    @(negedge clk);
    total++;
    if (u_if.uart_send !== 1'b0) begin bad++; $display("FAIL single_send_lo: got %b, required 0", u_if.uart_send); end
    repeat (FRAME + 20) @(negedge clk);
    total += 2;
    if (sent_q.size() !== 1) begin bad++; $display("FAIL single_frames: got %0d, required 1", sent_q.size()); end
    else if (sent_q[0] !== 8'h55) begin bad++; $display("FAIL single_txd: got %h, required 55", sent_q[0]); end
  endtask
  task automatic test_burst();
    int peak = 0;
    logic ready_ok = 1'b1;
    do_reset();
    sent_q.delete();
    for (int i = 0; i < 16; i++) begin
      u_if.tx_data = 8'(i);
      u_if.tx_valid = 1'b1;
      if (u_if.tx_ready !== 1'b1) ready_ok = 1'b0;
      @(negedge clk);
      if (int'(u_if.tx_count) > peak) peak = int'(u_if.tx_count);
    end
    u_if.tx_valid = 1'b0;
    total += 2;
    if (!ready_ok) begin bad++; $display("FAIL burst_ready: got tx_ready=0 during burst, required 1"); end
    if (peak != 15) begin bad++; $display("FAIL burst_peak: got %0d, required 15", peak); end
    wait_sent(16, 1000);
    for (int i = 0; i < 16 && i < sent_q.size(); i++) begin
      total++;
      if (sent_q[i] !== 8'(i)) begin bad++; $display("FAIL burst_order[%0d]: got %h, required %h", i, sent_q[i], 8'(i)); end
    end
    repeat (FRAME + 10) @(negedge clk);
  endtask
  task automatic test_rx_single();
    int p;
    do_reset();
    u_if.rx_ready = 1'b0;
    send_rx(8'hA3, 1'b0, p);
    total += 4;
    if (p != 1) begin bad++; $display("FAIL rx_pulses: got %0d, required 1", p); end
    if (u_if.rx_valid !== 1'b1) begin bad++; $display("FAIL rx_valid: got %b, required 1", u_if.rx_valid); end
    if (u_if.rx_data !== 8'hA3) begin bad++; $display("FAIL rx_data: got %h, required a3", u_if.rx_data); end
    if (u_if.rx_count !== 5'd1) begin bad++; $display("FAIL rx_count: got %0d, required 1", u_if.rx_count); end
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.rx_ready = 1'b0;
    total++;
    if (u_if.rx_count !== 5'd0) begin bad++; $display("FAIL rx_pop_count: got %0d, required 0", u_if.rx_count); end
  endtask
  task automatic test_overflow();
    int p;
    do_reset();
    u_if.rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b0, p);
    total += 2;
    if (u_if.rx_count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d, required 16", u_if.rx_count); end
    if (u_if.rx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, required 1", u_if.rx_overflow); end
    u_if.rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (u_if.rx_data !== 8'(8'h10 + i)) begin bad++; $display("FAIL ovf_pop[%0d]: got %h, required %h", i, u_if.rx_data, 8'(8'h10 + i)); end
      @(negedge clk);
    end
    u_if.rx_ready = 1'b0;
    total++;
    if (u_if.rx_valid !== 1'b0) begin bad++; $display("FAIL ovf_lost: got rx_valid=%b data=%h, required empty", u_if.rx_valid, u_if.rx_data); end
    u_if.overflow_clear = 1'b1;
    @(negedge clk);
    u_if.overflow_clear = 1'b0;
    total++;
    if (u_if.rx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b, required 0", u_if.rx_overflow); end
    for (int i = 0; i < 16; i++) send_rx(8'(i), 1'b0, p);
    total++;
    if (u_if.rx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_exact_full: got %b, required 0", u_if.rx_overflow); end
    send_rx(8'h99, 1'b1, p);
    total++;
    if (u_if.rx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b, required 1", u_if.rx_overflow); end
  endtask
  task automatic test_reset_mid();
    int c = 0;
    int n;
    logic quiet = 1'b1;
    do_reset();
    sent_q.delete();
    for (int i = 0; i < 4; i++) begin
      u_if.tx_data = 8'(8'hA0 + i);
      u_if.tx_valid = 1'b1;
      @(negedge clk);
    end
    u_if.tx_valid = 1'b0;
    while (!u_if.uart_send_busy && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    total += 2;
    if (!u_if.uart_send_busy) begin bad++; $display("FAIL mid_busy: got busy=0, required 1"); end
    if (u_if.tx_count !== 5'd3) begin bad++; $display("FAIL mid_queued: got %0d, required 3", u_if.tx_count); end
    busy_force = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 2;
    if (u_if.tx_count !== 5'd0) begin bad++; $display("FAIL mid_flush: got %0d, required 0", u_if.tx_count); end
    if (u_if.uart_send !== 1'b0) begin bad++; $display("FAIL mid_send: got %b, required 0", u_if.uart_send); end
    n = sent_q.size();
    repeat (5) begin
      @(negedge clk);
      if (u_if.uart_send !== 1'b0) quiet = 1'b0;
    end
    busy_force = 1'b0;
    repeat (FRAME + 20) begin
      @(negedge clk);
      if (u_if.uart_send !== 1'b0) quiet = 1'b0;
    end
    total += 2;
    if (!quiet) begin bad++; $display("FAIL mid_quiet: got uart_send=1 after reset, required 0"); end
    if (sent_q.size() != n) begin bad++; $display("FAIL mid_frames: got %0d, required %0d", sent_q.size(), n); end
  endtask
  task automatic test_simultaneous();
    int p;
    do_reset();
    sent_q.delete();
    u_if.rx_ready = 1'b0;
    send_rx(8'h11, 1'b0, p);
    u_if.tx_data = 8'h3C;
    u_if.tx_valid = 1'b1;
    u_if.uart_rev_data = 8'hC3;
    u_if.uart_rev_data_valid = 1'b1;
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    u_if.rx_ready = 1'b0;
    total += 3;
    if (u_if.rx_count !== 5'd1) begin bad++; $display("FAIL sim_rx_count: got %0d, required 1", u_if.rx_count); end
    if (u_if.rx_data !== 8'hC3) begin bad++; $display("FAIL sim_rx_data: got %h, required c3", u_if.rx_data); end
    if (u_if.uart_rev_data_invalid !== 1'b1) begin bad++; $display("FAIL sim_ack: got %b, required 1", u_if.uart_rev_data_invalid); end
    u_if.uart_rev_data_valid = 1'b0;
    wait_sent(1, 100);
    total++;
    if (sent_q.size() > 0 && sent_q[0] !== 8'h3C) begin bad++; $display("FAIL sim_txd: got %h, required 3c", sent_q[0]); end
    repeat (FRAME + 10) @(negedge clk);
    total++;
    if (u_if.rx_count !== 5'd1) begin bad++; $display("FAIL sim_rx_final: got %0d, required 1", u_if.rx_count); end
  endtask
  initial begin
    u_if.tx_data = '0;
    u_if.tx_valid = 1'b0;
    u_if.rx_ready = 1'b0;
    u_if.overflow_clear = 1'b0;
    u_if.uart_rev_data = '0;
    u_if.uart_rev_data_valid = 1'b0;
    test_reset();
    test_single_tx();
    test_burst();
    test_rx_single();
    test_overflow();
    test_reset_mid();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
